seven_seg_capture: RTL and testbench

- Reader for a multiplexed seven-segment display bus: samples segment lines plus one-hot digit selects and filters glitches with a stability counter.
- Decodes each stable segment pattern back to BCD.
- Assembles a complete multi-digit frame and presents it to downstream logic over a valid/ready handshake.
- Sits at the capture/loop-back end of the display path, alongside the BCD-to-seven-segment encoder.

---
 rtl/seven_seg_capture.sv | 133 +++++++++++++
 tb/tb_seven_seg_capture.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// Multiplexed seven-segment bus reader: glitch-filters segment/digit samples,
// decodes to BCD and presents complete frames over valid/ready.
// Optional: SEVEN_SEG_CAPTURE_BLANK_DETECT_EN decodes an all-off digit as BCD 4'hA.
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    frame_ready,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    overrun
);

    localparam int         SW        = NUM_DIGITS + 7;
    localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);
    localparam logic [3:0] STABLE_M1 = 4'(STABLE_CYCLES - 1);

    typedef enum logic {COLLECT, PRESENT} state_t;

    state_t                  state;
    logic [SW-1:0]           samp;
    logic [SW-1:0]           samp_next;
    logic [3:0]              cnt;
    logic [NUM_DIGITS-1:0]   samp_dig;
    logic [6:0]              samp_seg;
    logic [3:0]              hot_cnt;
    logic                    commit;
    logic [NUM_DIGITS-1:0]   commit_mask;
    logic [NUM_DIGITS-1:0]   seen;
    logic [NUM_DIGITS-1:0]   seen_upd;
    logic [4*NUM_DIGITS-1:0] live_bcd;
    logic [NUM_DIGITS-1:0]   live_err;
    logic [3:0]              dec_bcd;
    logic                    dec_err;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = {1'b0, 4'h0};
            7'b0110000: decode = {1'b0, 4'h1};
            7'b1101101: decode = {1'b0, 4'h2};
            7'b1111001: decode = {1'b0, 4'h3};
            7'b0110011: decode = {1'b0, 4'h4};
            7'b1011011: decode = {1'b0, 4'h5};
            7'b1011111: decode = {1'b0, 4'h6};
            7'b1110000: decode = {1'b0, 4'h7};
            7'b1111111: decode = {1'b0, 4'h8};
            7'b1111011: decode = {1'b0, 4'h9};
`ifdef SEVEN_SEG_CAPTURE_BLANK_DETECT_EN
            7'b0000000: decode = {1'b0, 4'hA};
`endif
            default:    decode = {1'b1, 4'hF};
        endcase
    endfunction

    assign samp_next          = {dig_sel, seg_in};
    assign samp_dig           = samp[SW-1:7];
    assign samp_seg           = samp[6:0];
    assign {dec_err, dec_bcd} = decode(samp_seg);

    always_comb begin
        hot_cnt = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (samp_dig[i]) hot_cnt = hot_cnt + 4'd1;
        end
    end

    // The counter is about to reach STABLE on this edge: one commit per stable run.
    assign commit      = (cnt == STABLE_M1) && (samp_next == samp) && (hot_cnt == 4'd1);
    assign commit_mask = commit ? samp_dig : '0;
    assign seen_upd    = seen | commit_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp <= '0;
            cnt  <= '0;
        end else begin
            samp <= samp_next;
            if (samp_next != samp)
                cnt <= 4'd1;
            else if (cnt != STABLE)
                cnt <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            seen        <= '0;
            live_bcd    <= '0;
            live_err    <= '0;
            frame_valid <= 1'b0;
            frame_bcd   <= '0;
            frame_err   <= '0;
            overrun     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (commit_mask[i]) begin
                    live_bcd[4*i +: 4] <= dec_bcd;
                    live_err[i]        <= dec_err;
                end
            end
            case (state)
                COLLECT: begin
                    if (&seen) begin
                        // Snapshot takes pre-commit live values; a coincident commit seeds the new mask.
                        frame_bcd   <= live_bcd;
                        frame_err   <= live_err;
                        seen        <= commit_mask;
                        frame_valid <= 1'b1;
                        state       <= PRESENT;
                    end else begin
                        seen <= seen_upd;
                    end
                end
                PRESENT: begin
                    seen <= seen_upd;
                    if (&seen_upd) overrun <= 1'b1;
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        state       <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seven_seg_capture;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        frame_ready;
    logic        frame_valid;
    logic [15:0] frame_bcd;
    logic [3:0]  frame_err;
    logic        overrun;

    int vectors    = 0;
    int miscompares = 0;

    seven_seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_bcd   (frame_bcd),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive a digit/segment pair and hold it for n rising edges, returning 1 time unit after the last.
    task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
        dig_sel = d;
        seg_in  = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] blank_bcd;
    logic [3:0]  blank_err;

    initial begin
        rst_n       = 1'b0;
        seg_in      = '0;
        dig_sel     = '0;
        frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_valid",   16'(frame_valid), 16'h0);
        chk("reset_bcd",     frame_bcd,        16'h0);
        chk("reset_err",     16'(frame_err),   16'h0);
        chk("reset_overrun", 16'(overrun),     16'h0);

        // Nominal frame 3,4,9,0 with ready high
        drive(4'b0001, 7'b1111001, 6);
        drive(4'b0010, 7'b0110011, 6);
        drive(4'b0100, 7'b1111011, 6);
        drive(4'b1000, 7'b1111110, 4);
        chk("nom_not_yet",  16'(frame_valid), 16'h0);
        drive(4'b1000, 7'b1111110, 1);
        chk("nom_valid",    16'(frame_valid), 16'h1);
        chk("nom_bcd",      frame_bcd,        16'h0943);
        chk("nom_err",      16'(frame_err),   16'h0);
        drive(4'b1000, 7'b1111110, 1);
        chk("nom_pulse",    16'(frame_valid), 16'h0);

        // Glitch filter: 3-clock patterns never commit
        frame_ready = 1'b0;
        drive(4'b0001, 7'b0110000, 3);
        drive(4'b0010, 7'b0110011, 6);
        drive(4'b0100, 7'b1111011, 6);
        drive(4'b1000, 7'b1111110, 6);
        chk("glitch_no_frame", 16'(frame_valid), 16'h0);
        drive(4'b0001, 7'b0110000, 3);
        drive(4'b0001, 7'b1101101, 4);
        chk("glitch_commit_edge", 16'(frame_valid), 16'h0);
        drive(4'b0001, 7'b1101101, 1);
        chk("glitch_valid", 16'(frame_valid), 16'h1);
        chk("glitch_bcd",   frame_bcd,        16'h0942);
        frame_ready = 1'b1;
        drive(4'b0001, 7'b1101101, 1);
        chk("glitch_accept", 16'(frame_valid), 16'h0);

        // Invalid pattern on digit2, multi-hot select must not commit
        frame_ready = 1'b0;
        drive(4'b0001, 7'b1111001, 6);
        drive(4'b0100, 7'b1000001, 6);
        drive(4'b1000, 7'b1111110, 6);
        drive(4'b0011, 7'b1111111, 10);
        chk("multihot_no_frame", 16'(frame_valid), 16'h0);
        drive(4'b0010, 7'b0110011, 6);
        chk("inv_valid",   16'(frame_valid), 16'h1);
        chk("inv_bcd",     frame_bcd,        16'h0F43);
        chk("inv_err",     16'(frame_err),   16'h4);
        chk("inv_overrun", 16'(overrun),     16'h0);

        // Second frame 5,6,7,8 arrives under backpressure
        drive(4'b0001, 7'b1011011, 6);
        drive(4'b0010, 7'b1011111, 6);
        drive(4'b0100, 7'b1110000, 6);
        chk("ovr_not_yet", 16'(overrun), 16'h0);
        drive(4'b1000, 7'b1111111, 4);
        chk("ovr_set",     16'(overrun),     16'h1);
        chk("ovr_valid",   16'(frame_valid), 16'h1);
        chk("ovr_frozen",  frame_bcd,        16'h0F43);
        chk("ovr_err",     16'(frame_err),   16'h4);
        frame_ready = 1'b1;
        drive(4'b1000, 7'b1111111, 1);
        chk("ovr_accept",  16'(frame_valid), 16'h0);
        frame_ready = 1'b0;
        drive(4'b1000, 7'b1111111, 1);
        chk("ovr_second_valid", 16'(frame_valid), 16'h1);
        chk("ovr_second_bcd",   frame_bcd,        16'h8765);
        chk("ovr_sticky",       16'(overrun),     16'h1);

        // Asynchronous reset while a frame is presented
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid",   16'(frame_valid), 16'h0);
        chk("async_bcd",     frame_bcd,        16'h0);
        chk("async_err",     16'(frame_err),   16'h0);
        chk("async_overrun", 16'(overrun),     16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b0001, 7'b0110000, 6);
        drive(4'b0010, 7'b1101101, 6);
        drive(4'b0100, 7'b1011011, 6);
        drive(4'b1000, 7'b1111011, 4);
        chk("post_reset_no_frame", 16'(frame_valid), 16'h0);
        drive(4'b1000, 7'b1111011, 1);
        chk("post_reset_valid", 16'(frame_valid), 16'h1);
        chk("post_reset_bcd",   frame_bcd,        16'h9521);
        frame_ready = 1'b1;
        drive(4'b1000, 7'b1111011, 1);
        chk("post_reset_accept", 16'(frame_valid), 16'h0);

        // Blank digit on digit1
`ifdef SEVEN_SEG_CAPTURE_BLANK_DETECT_EN
        blank_bcd = 16'h04A3;
        blank_err = 4'b0000;
`else
        blank_bcd = 16'h04F3;
        blank_err = 4'b0010;
`endif
        drive(4'b0001, 7'b1111001, 6);
        drive(4'b0010, 7'b0000000, 6);
        drive(4'b0100, 7'b0110011, 6);
        drive(4'b1000, 7'b1111110, 5);
        chk("blank_valid", 16'(frame_valid), 16'h1);
        chk("blank_bcd",   frame_bcd,        blank_bcd);
        chk("blank_err",   16'(frame_err),   16'(blank_err));
        drive(4'b1000, 7'b1111110, 1);
        chk("blank_pulse", 16'(frame_valid), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
